// File: rtl/synth_pkg.sv
// Shared definitions for the per-voice synth blocks.
//   env_state_t : envelope state encoding (IDLE..RELEASE), also exported as a debug port
//   ENV_MAX     : full-scale envelope level for the default 16-bit level width
//   VEL_*       : velocity width, ceiling and the shift that normalises it
//   MIDI_*/VEL_*: field positions inside the 16-bit note word
package synth_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } env_state_t;

  localparam logic [15:0] ENV_MAX = 16'hFFFF;

  localparam int unsigned VEL_W     = 7;
  localparam logic [7:0]  VEL_MAX   = 8'd127;
  localparam int unsigned VEL_SHIFT = 7;

  localparam int unsigned MIDI_HI = 14;
  localparam int unsigned MIDI_LO = 8;
  localparam int unsigned VEL_HI  = 7;
  localparam int unsigned VEL_LO  = 0;

  // The note word carries a full byte of velocity; anything above 127 is clipped.
  function automatic logic [VEL_W-1:0] sat_vel(input logic [7:0] vel);
    return (vel > VEL_MAX) ? VEL_MAX[VEL_W-1:0] : vel[VEL_W-1:0];
  endfunction

endpackage

// File: rtl/env_scaler.sv
// Registered signed x unsigned multiply followed by an arithmetic right shift.
// The coefficient is zero-extended so the product is (DATA_W+COEF_W+1) bits signed; the
// output keeps bits [SHIFT+DATA_W-1:SHIFT] (truncation toward -inf, no rounding).
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clk_en       : sample tick; the register only loads when high
//   i_sample     : signed input sample
//   i_coef       : unsigned scale factor
//   i_valid      : qualifier travelling alongside the sample
//   o_sample     : registered scaled sample
//   o_valid      : registered qualifier
module env_scaler #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned SHIFT  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic        [COEF_W-1:0] i_coef,
  input  logic                     i_valid,
  output logic signed [DATA_W-1:0] o_sample,
  output logic                     o_valid
);

  localparam int unsigned PROD_W = DATA_W + COEF_W + 1;

  logic signed [PROD_W-1:0] w_prod;
  logic                     w_unused;

  assign w_prod = i_sample * $signed({1'b0, i_coef});

  // Discarded guard/fraction bits of the product.
  assign w_unused = ^{w_prod[PROD_W-1:SHIFT+DATA_W], w_prod[SHIFT-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_sample <= '0;
      o_valid  <= 1'b0;
    end else if (clk_en) begin
      o_sample <= w_prod[SHIFT+DATA_W-1:SHIFT];
      o_valid  <= i_valid;
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope with velocity scaling for one synth voice.
// Optional feature macro: ADSR_VELOCITY_EN (defined = second stage scales by the latched
// velocity; undefined = second stage is a plain register, latency unchanged).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   clk_en          : sample tick; all state advances only when high
//   i_data          : note word [14:8] midi, [7:0] velocity; nonzero = gate on
//   i_ready         : upstream sample is valid; otherwise the sample is treated as 0
//   i_signal        : signed upstream sample
//   i_attack_step   : level increment per tick in ATTACK
//   i_decay_step    : level decrement per tick in DECAY
//   i_sustain_lvl   : sustain level
//   i_release_step  : level decrement per tick in RELEASE
//   o_signal        : enveloped sample, 2 ticks after the input
//   o_valid         : i_ready delayed by 2 ticks
//   o_active        : envelope is not IDLE
//   o_stage         : current envelope state (debug)
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LEVEL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic [15:0]              i_data,
  input  logic                     i_ready,
  input  logic signed [DATA_W-1:0] i_signal,
  input  logic [LEVEL_W-1:0]       i_attack_step,
  input  logic [LEVEL_W-1:0]       i_decay_step,
  input  logic [LEVEL_W-1:0]       i_sustain_lvl,
  input  logic [LEVEL_W-1:0]       i_release_step,
  output logic signed [DATA_W-1:0] o_signal,
  output logic                     o_valid,
  output logic                     o_active,
  output logic [2:0]               o_stage
);

  // Full scale for the configured level width (equals ENV_MAX at the default width).
  localparam logic [LEVEL_W-1:0] LvlMax = {LEVEL_W{1'b1}};

  env_state_t         r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [15:0]        r_note;
  logic [VEL_W-1:0]   r_vel;

  logic               w_gate;
  logic               w_start;
  logic [LEVEL_W:0]   w_att_sum;
  logic               w_att_top;
  logic [LEVEL_W:0]   w_dec_floor;
  logic               w_dec_hit;
  logic               w_rel_hit;

  assign w_gate  = (i_data != '0);
  // Start from IDLE on any gate, or retrigger on a different note word.
  assign w_start = w_gate && ((r_state == StIdle) || (i_data != r_note));

  // One extra bit so the comparisons cannot wrap.
  assign w_att_sum   = {1'b0, r_level} + {1'b0, i_attack_step};
  assign w_att_top   = (w_att_sum >= {1'b0, LvlMax});
  assign w_dec_floor = {1'b0, i_sustain_lvl} + {1'b0, i_decay_step};
  assign w_dec_hit   = ({1'b0, r_level} <= w_dec_floor);
  assign w_rel_hit   = (r_level <= i_release_step);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_level <= '0;
      r_note  <= '0;
      r_vel   <= '0;
    end else if (clk_en) begin
      if (!w_gate && (r_state inside {StAttack, StDecay, StSustain})) begin
        // Gate off wins over retrigger; level carries over unchanged.
        r_state <= StRelease;
      end else if (w_start) begin
        r_state <= StAttack;
        r_note  <= i_data;
        r_vel   <= sat_vel(i_data[VEL_HI:VEL_LO]);
      end else begin
        case (r_state)
          StIdle: ;
          StAttack: begin
            if (w_att_top) begin
              r_level <= LvlMax;
              r_state <= StDecay;
            end else begin
              r_level <= w_att_sum[LEVEL_W-1:0];
            end
          end
          StDecay: begin
            if (w_dec_hit) begin
              r_level <= i_sustain_lvl;
              r_state <= StSustain;
            end else begin
              r_level <= r_level - i_decay_step;
            end
          end
          StSustain: r_level <= i_sustain_lvl;
          StRelease: begin
            if (w_rel_hit) begin
              r_level <= '0;
              r_state <= StIdle;
            end else begin
              r_level <= r_level - i_release_step;
            end
          end
          default: begin
            r_state <= StIdle;
            r_level <= '0;
          end
        endcase
      end
    end
  end

  assign o_stage  = r_state;
  assign o_active = (r_state != StIdle);

  // Datapath: stage1 scales by the pre-update level, stage2 by velocity.
  logic signed [DATA_W-1:0] w_s1_in;
  logic signed [DATA_W-1:0] w_s1;
  logic                     w_s1_valid;

  assign w_s1_in = i_ready ? i_signal : '0;

  env_scaler #(
    .DATA_W (DATA_W),
    .COEF_W (LEVEL_W),
    .SHIFT  (LEVEL_W)
  ) u_stage1 (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .i_sample (w_s1_in),
    .i_coef   (r_level),
    .i_valid  (i_ready),
    .o_sample (w_s1),
    .o_valid  (w_s1_valid)
  );

`ifdef ADSR_VELOCITY_EN
  env_scaler #(
    .DATA_W (DATA_W),
    .COEF_W (VEL_W),
    .SHIFT  (VEL_SHIFT)
  ) u_stage2 (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .i_sample (w_s1),
    .i_coef   (r_vel),
    .i_valid  (w_s1_valid),
    .o_sample (o_signal),
    .o_valid  (o_valid)
  );
`else
  // Velocity is still latched so the feature can be enabled without other changes.
  logic w_unused_vel;
  assign w_unused_vel = ^r_vel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_signal <= '0;
      o_valid  <= 1'b0;
    end else if (clk_en) begin
      o_signal <= w_s1;
      o_valid  <= w_s1_valid;
    end
  end
`endif

endmodule
